// File: rtl/iter_comparator_pkg.sv
// Shared types for the iterative comparator: condition codes, FSM states and
// the condition evaluator that maps lt/eq onto the selected op.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_LT = 3'd0,
        CMP_LE = 3'd1,
        CMP_EQ = 3'd2,
        CMP_NE = 3'd3,
        CMP_GT = 3'd4,
        CMP_GE = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

    // Codes 6 and 7 are reserved and always evaluate false.
    function automatic logic cmp_eval(input logic [2:0] op, input logic lt, input logic eq);
        logic r;
        r = 1'b0;
        case (op)
            CMP_LT:  r = lt;
            CMP_LE:  r = lt | eq;
            CMP_EQ:  r = eq;
            CMP_NE:  r = ~eq;
            CMP_GT:  r = ~lt & ~eq;
            CMP_GE:  r = ~lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iter_comparator_chunk_cmp.sv
// Unsigned magnitude compare of one CHUNK-bit slice of the two operands.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    output logic             c_lt,
    output logic             c_eq
);

    assign c_lt = (a_c < b_c);
    assign c_eq = (a_c == b_c);

endmodule

// File: rtl/iter_comparator.sv
// Multi-cycle signed/unsigned comparator, MSB chunk first, CHUNK bits per cycle.
// Build option ITER_COMPARATOR_EARLY_EXIT_EN: stop at the first differing chunk.
module iter_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             res
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("iter_comparator: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lt_q, lt_d, eq_q, eq_d, res_q, res_d;
    logic             c_lt, c_eq;
`ifndef ITER_COMPARATOR_EARLY_EXIT_EN
    logic             found_q, found_d, flt_q, flt_d;
`endif

    // Operands shift left each cycle so the chunk under test is always the top slice.
    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a_c  (a_q[WIDTH-1 -: CHUNK]),
        .b_c  (b_q[WIDTH-1 -: CHUNK]),
        .c_lt (c_lt),
        .c_eq (c_eq)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        res_d   = res_q;
`ifndef ITER_COMPARATOR_EARLY_EXIT_EN
        found_d = found_q;
        flt_d   = flt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d     = is_signed ? (a ^ SIGN_MASK) : a;
                    b_d     = is_signed ? (b ^ SIGN_MASK) : b;
                    op_d    = op;
                    idx_d   = IDX_W'(NCHUNK - 1);
`ifndef ITER_COMPARATOR_EARLY_EXIT_EN
                    found_d = 1'b0;
                    flt_d   = 1'b0;
`endif
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                a_d   = a_q << CHUNK;
                b_d   = b_q << CHUNK;
                idx_d = idx_q - IDX_W'(1);
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
                if (!c_eq || idx_q == '0) begin
                    lt_d    = c_lt;
                    eq_d    = c_eq;
                    res_d   = cmp_eval(op_q, lt_d, eq_d);
                    state_d = DONE;
                end
`else
                if (!found_q && !c_eq) begin
                    found_d = 1'b1;
                    flt_d   = c_lt;
                end
                if (idx_q == '0) begin
                    lt_d    = found_q ? flt_q : c_lt;
                    eq_d    = ~found_q & c_eq;
                    res_d   = cmp_eval(op_q, lt_d, eq_d);
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            res_q   <= res_d;
        end
    end

`ifndef ITER_COMPARATOR_EARLY_EXIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_q <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            found_q <= found_d;
            flt_q   <= flt_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign res       = res_q;

endmodule

// File: tb/tb_iter_comparator.sv
// Scoreboard bench for iter_comparator (WIDTH=32, CHUNK=8): random and directed
// compares against an arithmetic reference model, plus backpressure and reset cases.
module tb_iter_comparator;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic lt;
        logic eq;
        logic res;
        int   lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             is_signed = 1'b0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             lt, eq, res;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    iter_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt        (lt),
        .eq        (eq),
        .res       (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic, latency from the first differing byte.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic s, input logic [2:0] o);
        exp_t e;
        int   k;
        logic hit;
        e.lt = s ? ($signed(av) < $signed(bv)) : (av < bv);
        e.eq = (av == bv);
        case (o)
            3'd0: e.res = e.lt;
            3'd1: e.res = e.lt || e.eq;
            3'd2: e.res = e.eq;
            3'd3: e.res = !e.eq;
            3'd4: e.res = !e.lt && !e.eq;
            3'd5: e.res = !e.lt;
            default: e.res = 1'b0;
        endcase
        k   = NCHUNK;
        hit = 1'b0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (!hit && av[WIDTH-1-i*CHUNK -: CHUNK] != bv[WIDTH-1-i*CHUNK -: CHUNK]) begin
                k   = i + 1;
                hit = 1'b1;
            end
        end
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
        e.lat = k;
`else
        e.lat = NCHUNK;
`endif
        return e;
    endfunction

    // Monitor: measures latency and compares every handshaken result with the scoreboard.
    initial begin
        int   acc_cyc;
        int   lat_seen;
        logic prev_ov;
        exp_t e;
        acc_cyc  = 0;
        lat_seen = 0;
        prev_ov  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_cyc = cyc + 1;
                if (out_valid && !prev_ov) lat_seen = cyc - acc_cyc;
                prev_ov = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("lt", 32'(lt), 32'(e.lt));
                        check("eq", 32'(eq), 32'(e.eq));
                        check("res", 32'(res), 32'(e.res));
                        check("latency", 32'(lat_seen), 32'(e.lat));
                    end
                end
            end
        end
    end

    // Driver: one full transaction; inputs move on posedge+1, outputs sampled at negedge.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic s, input logic [2:0] o, input int hold, input bit chk_hold);
        int   t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        e = model(av, bv, s, o);
        sb.push_back(e);
        a = av; b = bv; is_signed = s; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom); op = 3'($urandom);
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (chk_hold) begin
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_lt", 32'(lt), 32'(e.lt));
                check("hold_eq", 32'(eq), 32'(e.eq));
                check("hold_res", 32'(res), 32'(e.res));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int               ov_seen;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {29'd0, lt, eq, res}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3'd0, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd0, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd0, 0, 1'b0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd2, 0, 1'b0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd3, 0, 1'b0);
        do_op(32'h0000_0010, 32'h0000_0011, 1'b0, 3'd5, 0, 1'b0);
        do_op(32'h0000_0010, 32'h0000_0011, 1'b0, 3'd6, 0, 1'b0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd4, 1, 1'b0);

        // Backpressure: result must stay put while out_ready is low.
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3'd1, 5, 1'b1);

        // Reset during COMPARE: equal operands keep the block busy for NCHUNK cycles.
        a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; is_signed = 1'b0; op = 3'd2; in_valid = 1'b1;
        sb.push_back(model(a, b, 1'b0, 3'd2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", {29'd0, lt, eq, res}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        ov_seen = 0;
        repeat (NCHUNK + 2) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("midrst_no_valid", 32'(ov_seen), 32'd0);
        do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 3'd1, 0, 1'b0);

        // Random ops, biased so many operands share upper chunks.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom), 3'($urandom), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_comparator.md
Name: iter_comparator

Overview:
- Multi-cycle, parametrised successor to the single-cycle signed/unsigned less-than comparator.
- Compares two WIDTH-bit operands MSB-chunk-first, CHUNK bits per cycle.
- Returns lt/eq flags plus a selectable condition result (LT/LE/EQ/NE/GT/GE).
- Sits beside the ALU for wide or multicycle compares (branch resolution, slt on wide datapaths); valid/ready on both sides.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- op  input  3  cmp_op_e condition select.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- lt  output  1  a < b, registered.
- eq  output  1  a == b, registered.
- res  output  1  op applied to lt/eq, registered.

Behaviour:
- Reset (async assert, deassert synchronous to clk): state=IDLE; out_valid=0; lt=eq=res=0; in_ready=1 after release.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready: latch a, b and op. If is_signed, invert bit WIDTH-1 of both latched operands (signed compare reduces to unsigned). Set idx=NCHUNK-1. -> COMPARE.
  - COMPARE: one chunk per cycle, chunk[idx] of a vs b.
    - Chunks differ: lt=(a_chunk<b_chunk), eq=0, -> DONE.
    - Equal and idx==0: lt=0, eq=1, -> DONE.
    - Otherwise: idx-1, stay in COMPARE.
  - DONE: out_valid=1; lt/eq/res stable. On out_ready -> IDLE, out_valid drops the next cycle.
- res mapping:
  - LT=lt; LE=lt|eq; EQ=eq; NE=~eq; GT=~lt&~eq; GE=~lt.
  - Codes 6/7: res=0.
- Latency (accept edge to out_valid high): k cycles, where k = position of the first differing chunk counted from the MSB (1..NCHUNK); equal operands give NCHUNK. CHUNK==WIDTH gives 1 cycle.
- Throughput: no overlap. New accept only in IDLE, so at least k+2 cycles per op.
- Operands are registered at accept; input changes after accept have no effect.
- Reset mid-COMPARE or mid-DONE: operation abandoned, no out_valid pulse, outputs cleared.
- lt/eq/res update only on the COMPARE->DONE transition. They hold their last value in IDLE.

Optional Feature:
- Macro: ITER_COMPARATOR_EARLY_EXIT_EN.
- Defined: early exit on the first differing chunk; latency k as above.
- Undefined: always scan all NCHUNK chunks (fixed latency NCHUNK). The first difference is recorded in a sticky flag and later chunks do not overwrite lt. Final lt/eq are identical to the early-exit build.

Decomposition:
- Package cmp_pkg:
  - cmp_op_e (3-bit): CMP_LT=0, CMP_LE=1, CMP_EQ=2, CMP_NE=3, CMP_GT=4, CMP_GE=5.
  - cmp_state_e: IDLE, COMPARE, DONE.
  - Function cmp_eval(op, lt, eq) returning res.
- Sub-module chunk_cmp:
  - Combinational, parametrised by CHUNK.
  - Inputs a_c, b_c; outputs c_lt, c_eq (unsigned).

Test Plan (WIDTH=32, CHUNK=8):
- Unsigned a=0x0000_0001, b=0xFFFF_FFFF, op=LT -> res=1, lt=1, eq=0; out_valid 1 cycle after accept with EARLY_EXIT_EN, 4 without.
- a=0xFFFF_FFFF, b=0x0000_0001, op=LT:
  - is_signed=1 -> res=1 (-1 < 1).
  - is_signed=0 -> res=0.
- a=b=0x1234_5678, op=EQ then op=NE -> res=1 then 0, eq=1, latency 4 in both builds.
- a=0x0000_0010, b=0x0000_0011, op=GE -> res=0, lt=1, latency 4; op=6 with same operands -> res=0.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_valid, lt, eq, res stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, next op accepted.
- rst pulsed during COMPARE (no-early-exit build, cycle 2):
  - out_valid never asserts; lt=eq=res=0 immediately.
  - in_ready=1 after release.
  - Subsequent op completes correctly.
